cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 Parameters: none; IMEM_WORDS=64 and DMEM_WORDS=64 are fixed internal constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 initialize  input  1  1 = program-load mode (instruction memory writable, execution halted).
REQ-005 instruction_initialize_data  input  32  instruction word written in load mode.
REQ-006 instruction_initialize_address  input  32  byte address for load-mode writes; word index = bits [7:2].
REQ-007 The block SHALL have no functional outputs; state SHALL be observed through the internal arrays regs[0:31] (32 bit) and dmem[0:63] (32 bit) and the register pc (32 bit).

Function
REQ-008 The block SHALL be a single-cycle 32-bit MIPS subset: fetch, decode, execute, memory and writeback in one clock.
REQ-009 While initialize=1, each rising edge SHALL write instruction_initialize_data to imem[addr[7:2]], pc SHALL hold, and no register or data-memory write SHALL occur.
REQ-010 While initialize=0 and rst=0, each rising edge SHALL retire exactly one instruction, imem[pc[7:2]].
REQ-011 R-type (opcode 0x00) funct codes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A; result goes to rd.
REQ-012 I-type: ADDI 0x08 (rt=rs+sext(imm)), LW 0x23 (rt=dmem[(rs+sext(imm))[7:2]]), SW 0x2B (dmem[...]=rt), LUI 0x0F (rt={imm,16'h0}).
REQ-013 Branches: BEQ 0x04, BNE 0x05; when taken, pc = pc+4+(sext(imm)<<2); otherwise pc = pc+4.
REQ-014 J 0x02: pc = {(pc+4)[31:28], target26, 2'b00}.
REQ-015 Arithmetic SHALL wrap modulo 2^32, with no overflow trap; SLT SHALL compare signed and write 1 or 0.
REQ-016 Writes to register 0 SHALL be discarded; regs[0] SHALL always read 0.
REQ-017 Register and memory reads SHALL be combinational; writes SHALL happen on the rising edge, so a read of a register written by the same instruction returns the old value.
REQ-018 Memory addresses SHALL use bits [7:2] only: low two bits ignored, addresses above 255 wrap.
REQ-019 Undefined opcodes or funct codes SHALL execute as NOP (pc+4, no writes).

Reset
REQ-020 When rst=1, asynchronously: pc=0, regs[i]=i for i=0..31, dmem[i]=0 for i=0..63.
REQ-021 imem SHALL NOT be cleared by rst; load-mode writes SHALL still occur while rst=1.
REQ-022 After rst deasserts with initialize=0, the first rising edge SHALL execute imem[0].

Structure
REQ-023 A shared package SHALL hold opcode and funct constants and the memory-depth constants.
REQ-024 The register file SHALL be one sub-module, cpu_regfile, with 2 read ports and 1 write port; the ALU, control decode, imem and dmem SHALL be inline.

Verification
REQ-025 Program load: write ADD R1,R0,R2 @0; SUB R8,R4,R4 @4; OR R7,R5,R6 @8; SW R9,12(R0) @12; LW R12,12(R0) @16; SLT R9,R7,R10 @20; ADDI R2,R3,3 @24; J 3 @28; ADD R17,R0,R4 @44; then release rst -> after 7 clocks R1=2, R8=0, R7=7, dmem[3]=9, R12=9, R9=1, R2=6.
REQ-026 Jump: on the 8th clock pc=12 and R17 stays 17; on the next pass the SW stores 1, so dmem[3]=1 and R12=1.
REQ-027 Branch: BEQ R0,R0,3 @0 -> pc=16; BNE R1,R1,3 @0 -> pc=4.
REQ-028 LUI R1,15 -> R1=0x000F0000; ADD R0,R1,R2 -> R0 stays 0.
REQ-029 Signed and wrap: SUB R1,R0,R2 then SLT R3,R1,R0 -> R1=0xFFFFFFFE, R3=1.
REQ-030 Reset mid-run: asserting rst between edges immediately gives pc=0 and regs[i]=i, while imem is preserved.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle MIPS-subset core: memory depths,
// opcode/funct encodings and the ALU operation type.
package cpu_pkg;

    localparam int unsigned IMEM_WORDS = 64;
    localparam int unsigned DMEM_WORDS = 64;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// Reset loads regs[i] = i; register 0 is hard-wired to zero.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs[raddr_b_i];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core. imem is loaded while initialize=1 and is
// never cleared by reset; all architectural writes are suppressed in load mode.
module cpu
    import cpu_pkg::*;
(
    input logic        clk,
    input logic        rst,
    input logic        initialize,
    input logic [31:0] instruction_initialize_data,
    input logic [31:0] instruction_initialize_address
);

    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    logic        reg_we;
    logic        mem_we;
    logic        wsel_mem;
    logic        wsel_lui;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  mem_idx;

    assign instr         = imem[pc[7:2]];
    assign opcode        = instr[31:26];
    assign rs            = instr[25:21];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    assign imm_sext      = sext16(imm);
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

    cpu_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (reg_we & ~initialize),
        .waddr_i   (waddr),
        .wdata_i   (wdata)
    );

    // Undefined opcodes/functs fall through with every enable low: a NOP.
    always_comb begin
        alu_op      = AluAdd;
        alu_src_imm = 1'b1;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        wsel_mem    = 1'b0;
        wsel_lui    = 1'b0;
        waddr       = rt;
        pc_d        = pc_plus4;
        case (opcode)
            OpRtype: begin
                alu_src_imm = 1'b0;
                waddr       = rd;
                case (funct)
                    FnAdd: begin reg_we = 1'b1; alu_op = AluAdd; end
                    FnSub: begin reg_we = 1'b1; alu_op = AluSub; end
                    FnAnd: begin reg_we = 1'b1; alu_op = AluAnd; end
                    FnOr:  begin reg_we = 1'b1; alu_op = AluOr;  end
                    FnSlt: begin reg_we = 1'b1; alu_op = AluSlt; end
                    default: ;
                endcase
            end
            OpAddi: reg_we = 1'b1;
            OpLw: begin
                reg_we   = 1'b1;
                wsel_mem = 1'b1;
            end
            OpSw:   mem_we = 1'b1;
            OpLui: begin
                reg_we   = 1'b1;
                wsel_lui = 1'b1;
            end
            OpBeq:  if (rdata_a == rdata_b) pc_d = branch_target;
            OpBne:  if (rdata_a != rdata_b) pc_d = branch_target;
            OpJ:    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
    end

    assign alu_b = alu_src_imm ? imm_sext : rdata_b;

    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            AluAdd: alu_y = rdata_a + alu_b;
            AluSub: alu_y = rdata_a - alu_b;
            AluAnd: alu_y = rdata_a & alu_b;
            AluOr:  alu_y = rdata_a | alu_b;
            AluSlt: alu_y = {31'd0, ($signed(rdata_a) < $signed(alu_b))};
            default: alu_y = 32'd0;
        endcase
    end

    assign mem_idx = alu_y[7:2];
    assign wdata   = wsel_mem ? dmem[mem_idx] :
                     wsel_lui ? {imm, 16'h0000} : alu_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
        end else if (!initialize) begin
            pc <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= 32'd0;
            end
        end else if (mem_we && !initialize) begin
            dmem[mem_idx] <= rdata_b;
        end
    end

    // Program loading is independent of rst so a load can overlap reset.
    always_ff @(posedge clk) begin
        if (initialize) begin
            imem[instruction_initialize_address[7:2]] <= instruction_initialize_data;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instr[10:6], instruction_initialize_address[31:8],
                           instruction_initialize_address[1:0]};

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random programs compared
// against an instruction-level reference model.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0;
    logic [31:0] idata = 32'd0;
    logic [31:0] iaddr = 32'd0;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog   [64];
    logic [31:0] m_imem [64];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;

    cpu dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (init),
        .instruction_initialize_data    (idata),
        .instruction_initialize_address (iaddr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(int f, int rd, int rs, int rt);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, f[5:0]};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rt, int rs, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] j_ins(int t);
        return {6'h02, t[25:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
        for (int i = 0; i < 64; i++) m_dmem[i] = 32'd0;
    endtask

    function automatic void m_wr(int r, logic [31:0] v);
        if (r != 0) m_regs[r] = v;
    endfunction

    // Instruction-set interpreter: one call retires one instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, npc, ea;
        int          rs, rt, rd;
        ins  = m_imem[m_pc[7:2]];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = m_pc + 4;
        ea   = a + simm;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m_wr(rd, a + b);
                6'h22: m_wr(rd, a - b);
                6'h24: m_wr(rd, a & b);
                6'h25: m_wr(rd, a | b);
                6'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h08: m_wr(rt, ea);
            6'h23: m_wr(rt, m_dmem[(ea / 4) % 64]);
            6'h2B: m_dmem[(ea / 4) % 64] = b;
            6'h0F: m_wr(rt, {ins[15:0], 16'h0000});
            6'h04: if (a == b) npc = npc + simm * 4;
            6'h05: if (a != b) npc = npc + simm * 4;
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    // Loads all 64 words under reset, with noise in the ignored address bits.
    task automatic load_prog();
        @(negedge clk);
        rst  = 1'b1;
        init = 1'b1;
        for (int i = 0; i < 64; i++) begin
            iaddr = {$urandom_range(0, 255) * 24'd1, 6'(i), 2'($urandom_range(0, 3))};
            idata = prog[i];
            m_imem[i] = prog[i];
            @(negedge clk);
        end
        init = 1'b0;
        model_reset();
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_r5", dut.u_regfile.regs[5], 32'd5);
        chk("reset_r31", dut.u_regfile.regs[31], 32'd31);
        chk("reset_dmem3", dut.dmem[3], 32'd0);
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++) chk({tag, "_reg"}, dut.u_regfile.regs[i], m_regs[i]);
        for (int i = 0; i < 64; i++) chk({tag, "_dmem"}, dut.dmem[i], m_dmem[i]);
    endtask

    function automatic logic [31:0] rand_ins();
        int k, rs, rt, rd, imm;
        int fn [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        k   = int'($urandom_range(0, 11));
        rs  = int'($urandom_range(0, 31));
        rt  = int'($urandom_range(0, 31));
        rd  = int'($urandom_range(0, 31));
        imm = int'($urandom_range(0, 65535));
        case (k)
            0, 1, 2, 3, 4: return r_ins(fn[k], rd, rs, rt);
            5:  return r_ins(int'($urandom_range(0, 31)), rd, rs, rt);
            6:  return i_ins(32'h08, rt, rs, imm);
            7:  return i_ins(32'h23, rt, rs, imm);
            8:  return i_ins(32'h2B, rt, rs, imm);
            9:  return i_ins(32'h0F, rt, rs, imm);
            10: return i_ins($urandom_range(0, 1) ? 32'h04 : 32'h05,
                             $urandom_range(0, 1) ? rs : rt, rs, imm);
            default: return $urandom_range(0, 1) ? j_ins(int'($urandom_range(0, 63)))
                                                 : i_ins(32'h3F, rt, rs, imm);
        endcase
    endfunction

    initial begin
        // Basic program with a jump back into it.
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0]  = r_ins(32'h20, 1, 0, 2);
        prog[1]  = r_ins(32'h22, 8, 4, 4);
        prog[2]  = r_ins(32'h25, 7, 5, 6);
        prog[3]  = i_ins(32'h2B, 9, 0, 12);
        prog[4]  = i_ins(32'h23, 12, 0, 12);
        prog[5]  = r_ins(32'h2A, 9, 7, 10);
        prog[6]  = i_ins(32'h08, 2, 3, 3);
        prog[7]  = j_ins(3);
        prog[11] = r_ins(32'h20, 17, 0, 4);
        load_prog();
        step(7);
        chk("basic_r1", dut.u_regfile.regs[1], 32'd2);
        chk("basic_r8", dut.u_regfile.regs[8], 32'd0);
        chk("basic_r7", dut.u_regfile.regs[7], 32'd7);
        chk("basic_dmem3", dut.dmem[3], 32'd9);
        chk("basic_r12", dut.u_regfile.regs[12], 32'd9);
        chk("basic_r9", dut.u_regfile.regs[9], 32'd1);
        chk("basic_r2", dut.u_regfile.regs[2], 32'd6);
        step(1);
        chk("jump_pc", dut.pc, 32'd12);
        chk("jump_r17", dut.u_regfile.regs[17], 32'd17);
        step(2);
        chk("pass2_dmem3", dut.dmem[3], 32'd1);
        chk("pass2_r12", dut.u_regfile.regs[12], 32'd1);
        check_all("basic");

        // Load mode with rst low: pc and state must hold while imem is written.
        init  = 1'b1;
        iaddr = 32'd252;
        idata = i_ins(32'h08, 5, 5, 1);
        m_imem[63] = idata;
        @(negedge clk);
        @(negedge clk);
        init = 1'b0;
        chk("load_hold_pc", dut.pc, m_pc);
        check_all("load_hold");
        chk("load_imem63", dut.imem[63], m_imem[63]);

        // Reset between edges, then rerun from imem[0].
        step(3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_pc", dut.pc, 32'd0);
        chk("midrst_r1", dut.u_regfile.regs[1], 32'd1);
        chk("midrst_r12", dut.u_regfile.regs[12], 32'd12);
        chk("midrst_dmem3", dut.dmem[3], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_imem0", dut.imem[0], prog[0]);
        step(1);
        chk("midrst_r1_after", dut.u_regfile.regs[1], 32'd2);
        chk("midrst_pc_after", dut.pc, 32'd4);

        // Branches.
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0] = i_ins(32'h04, 0, 0, 3);
        load_prog();
        step(1);
        chk("beq_taken_pc", dut.pc, 32'd16);
        prog[0] = i_ins(32'h05, 1, 1, 3);
        load_prog();
        step(1);
        chk("bne_not_taken_pc", dut.pc, 32'd4);

        // LUI, write to R0, signed compare after wrap.
        prog[0] = i_ins(32'h0F, 1, 0, 15);
        prog[1] = r_ins(32'h20, 0, 1, 2);
        prog[2] = r_ins(32'h22, 1, 0, 2);
        prog[3] = r_ins(32'h2A, 3, 1, 0);
        load_prog();
        step(1);
        chk("lui_r1", dut.u_regfile.regs[1], 32'h000F0000);
        step(1);
        chk("r0_stays_zero", dut.u_regfile.regs[0], 32'd0);
        step(2);
        chk("wrap_r1", dut.u_regfile.regs[1], 32'hFFFFFFFE);
        chk("slt_signed_r3", dut.u_regfile.regs[3], 32'd1);

        // Random programs against the reference model.
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 64; i++) prog[i] = rand_ins();
            load_prog();
            for (int s = 0; s < 60; s++) begin
                int r, d;
                step(1);
                r = int'($urandom_range(1, 31));
                d = int'($urandom_range(0, 63));
                chk("rand_pc", dut.pc, m_pc);
                chk("rand_reg", dut.u_regfile.regs[r], m_regs[r]);
                chk("rand_dmem", dut.dmem[d], m_dmem[d]);
            end
            check_all("rand_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
